// File: rtl/audio_sched_pkg.sv
// audio_sched_pkg: shared states, default width and the scale/clamp helper for the voice scheduler
package audio_sched_pkg;
    typedef enum logic [1:0] {IDLE, GATHER, SCALE, PRESENT} state_e;
    localparam int DW_DEF = 16;
    function automatic logic signed [31:0] sat_scale(input logic signed [31:0] acc, input logic [2:0] shift, input int dw);
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        s  = acc >>> shift;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        return (s > hi) ? hi : (s < lo) ? lo : s;
    endfunction
endpackage

// File: rtl/audio_sat_scale.sv
// audio_sat_scale: arithmetic right shift of one accumulator followed by a clamp to DW signed bits
module audio_sat_scale
    import audio_sched_pkg::*;
#(
    parameter int ACC_W = 18,
    parameter int DW    = DW_DEF
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic        [2:0]       shift_i,
    output logic signed [DW-1:0]    data_o
);
    always_comb data_o = DW'(sat_scale(32'(acc_i), shift_i, DW));
endmodule

// File: rtl/audio_voice_scheduler.sv
// audio_voice_scheduler: per-frame round-robin gather of stereo voices, scaled and
// saturated mix presented to the audio core's left/right sinks
module audio_voice_scheduler
    import audio_sched_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int DW         = DW_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_VOICES*DW-1:0] voice_data_l,
    input  logic [NUM_VOICES*DW-1:0] voice_data_r,
    input  logic [NUM_VOICES-1:0]    voice_valid,
    output logic [NUM_VOICES-1:0]    voice_ready,
    input  logic [NUM_VOICES-1:0]    voice_enable,
    input  logic [2:0]               vol_shift,
    output logic [DW-1:0]            left_data,
    output logic                     left_valid,
    input  logic                     left_ready,
    output logic [DW-1:0]            right_data,
    output logic                     right_valid,
    input  logic                     right_ready,
    output logic [15:0]              underrun_count,
    output logic [15:0]              frame_count,
    output logic                     busy
);
    localparam int IW    = $clog2(NUM_VOICES);
    localparam int ACC_W = DW + IW;

    state_e                   state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [DW-1:0]     ld_q, ld_d, rd_q, rd_d, sc_l, sc_r, cur_l, cur_r;
    logic                     lv_q, lv_d, rv_q, rv_d, busy_q;
    logic [15:0]              und_q, und_d, frm_q, frm_d;
    logic                     take, miss;

    audio_sat_scale #(.ACC_W(ACC_W), .DW(DW)) u_sat_l (.acc_i(acc_l_q), .shift_i(vol_shift), .data_o(sc_l));
    audio_sat_scale #(.ACC_W(ACC_W), .DW(DW)) u_sat_r (.acc_i(acc_r_q), .shift_i(vol_shift), .data_o(sc_r));

    always_comb begin
        voice_ready = '0;
        if (state_q == GATHER) voice_ready[idx_q] = voice_enable[idx_q];
    end

    assign cur_l = voice_data_l[idx_q*DW +: DW];
    assign cur_r = voice_data_r[idx_q*DW +: DW];
    assign take  = voice_ready[idx_q] & voice_valid[idx_q];
    assign miss  = voice_ready[idx_q] & ~voice_valid[idx_q];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        ld_d    = ld_q;
        rd_d    = rd_q;
        lv_d    = lv_q;
        rv_d    = rv_q;
        und_d   = und_q;
        frm_d   = frm_q;
        case (state_q)
            IDLE: begin
                acc_l_d = '0;
                acc_r_d = '0;
                idx_d   = '0;
                state_d = GATHER;
            end
            GATHER: begin
                acc_l_d = take ? acc_l_q + ACC_W'(cur_l) : acc_l_q;
                acc_r_d = take ? acc_r_q + ACC_W'(cur_r) : acc_r_q;
                und_d   = (miss && und_q != 16'hFFFF) ? und_q + 16'd1 : und_q;
                idx_d   = idx_q + IW'(1);
                state_d = (idx_q == IW'(NUM_VOICES - 1)) ? SCALE : GATHER;
            end
            SCALE: begin
                ld_d    = sc_l;
                rd_d    = sc_r;
                lv_d    = 1'b1;
                rv_d    = 1'b1;
                state_d = PRESENT;
            end
            default: begin
                lv_d = lv_q & ~left_ready;
                rv_d = rv_q & ~right_ready;
                // Frame completes only once both channels have been taken, in either order
                if (!lv_d && !rv_d) begin
                    frm_d   = frm_q + 16'd1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
            ld_q    <= '0;
            rd_q    <= '0;
            lv_q    <= 1'b0;
            rv_q    <= 1'b0;
            und_q   <= '0;
            frm_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            ld_q    <= ld_d;
            rd_q    <= rd_d;
            lv_q    <= lv_d;
            rv_q    <= rv_d;
            und_q   <= und_d;
            frm_q   <= frm_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign left_data      = ld_q;
    assign right_data     = rd_q;
    assign left_valid     = lv_q;
    assign right_valid    = rv_q;
    assign underrun_count = und_q;
    assign frame_count    = frm_q;
    assign busy           = busy_q;
endmodule
